// File: rtl/qpsk_frame_sync.sv
// QPSK frame synchroniser: hunts for SYNC_WORD in the 2-bit symbol stream and then packs payload
// symbols into bytes. Define SYNC_ERR_TOL_EN to accept a sync word with one bit in error.
module qpsk_frame_sync #(
  parameter logic [15:0] SYNC_WORD     = 16'hED8D,
  parameter int unsigned PAYLOAD_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym_i,
  input  logic       sym_valid_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_start_o,
  output logic       frame_done_o,
  output logic       locked_o
);

  typedef enum logic [0:0] {StHunt, StPayload} state_e;

  state_e      state_q, state_d;
  logic [15:0] sr_q, sr_d, sr_next;
  logic [3:0]  fill_q, fill_d, fill_next;
  logic [1:0]  sym_cnt_q, sym_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  asm_q, asm_d;
  logic [7:0]  byte_q, byte_d;
  logic        byte_valid_q, byte_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        match;

  // First symbol received ends up in sr[1:0] once eight symbols have been shifted in.
  assign sr_next   = {sym_i, sr_q[15:2]};
  assign fill_next = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;

`ifdef SYNC_ERR_TOL_EN
  logic [15:0] sync_diff;
  logic [4:0]  err_cnt;

  always_comb begin
    sync_diff = sr_next ^ SYNC_WORD;
    err_cnt   = 5'd0;
    for (int i = 0; i < 16; i++) begin
      err_cnt = err_cnt + 5'(sync_diff[i]);
    end
    match = (fill_next == 4'd8) && (err_cnt <= 5'd1);
  end
`else
  assign match = (fill_next == 4'd8) && (sr_next == SYNC_WORD);
`endif

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    fill_d        = fill_q;
    sym_cnt_d     = sym_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    asm_d         = asm_q;
    byte_d        = byte_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;

    if (sym_valid_i) begin
      case (state_q)
        StHunt: begin
          sr_d   = sr_next;
          fill_d = fill_next;
          if (match) begin
            state_d       = StPayload;
            frame_start_d = 1'b1;
            sym_cnt_d     = 2'd0;
            byte_cnt_d    = 8'd0;
          end
        end
        StPayload: begin
          asm_d[{sym_cnt_q, 1'b0} +: 2] = sym_i;
          sym_cnt_d                     = sym_cnt_q + 2'd1;
          if (sym_cnt_q == 2'd3) begin
            byte_d       = {sym_i, asm_q[5:0]};
            byte_valid_d = 1'b1;
            byte_cnt_d   = byte_cnt_q + 8'd1;
            if (byte_cnt_q == 8'(PAYLOAD_BYTES - 1)) begin
              // Frame complete: restart the hunt from an empty shift register.
              frame_done_d = 1'b1;
              state_d      = StHunt;
              sr_d         = 16'h0000;
              fill_d       = 4'd0;
              byte_cnt_d   = 8'd0;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StHunt;
      sr_q          <= 16'h0000;
      fill_q        <= 4'd0;
      sym_cnt_q     <= 2'd0;
      byte_cnt_q    <= 8'd0;
      asm_q         <= 8'h00;
      byte_q        <= 8'h00;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      fill_q        <= fill_d;
      sym_cnt_q     <= sym_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      byte_q        <= byte_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign byte_o        = byte_q;
  assign byte_valid_o  = byte_valid_q;
  assign frame_start_o = frame_start_q;
  assign frame_done_o  = frame_done_q;
  assign locked_o      = (state_q == StPayload);

endmodule
